// File: rtl/mem_reader.sv
// mem_reader: button-triggered read controller for the 8-bit data memory.
// A button press issues one read (btn[0]) or a scan of SCAN_LEN consecutive
// reads (btn[1]) starting at BASE_ADDR. btn[2] aborts and clears the output.
// Each word is presented on data_out with a one-cycle data_valid strobe.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   btn[2:0]      raw active-low buttons: [0] single, [1] scan, [2] clear
//   wr_busy       writer owns the RAM port this cycle; no read may issue
//   rd_en/rd_addr RAM read strobe and address
//   rd_data       RAM data, valid RD_LAT cycles after the rd_en cycle
//   data_out      last captured word
//   data_valid    one-cycle pulse when a new data_out appears
//   busy          controller is not idle
//   rd_count      words captured, saturating (only with MEM_READER_CNT_EN)
//
// Optional feature macro: MEM_READER_CNT_EN adds the rd_count output.
//
// state | meaning
// IDLE  | waiting for a single/scan command
// ISSUE | presenting rd_addr; read fires on the first cycle wr_busy is low
// WAIT  | counting down the RAM read latency, captures rd_data at zero

module mem_reader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int BASE_ADDR = 6,
    parameter int SCAN_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        btn,
    input  logic              wr_busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
`ifdef MEM_READER_CNT_EN
    ,
    output logic [7:0]        rd_count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    logic [2:0]        sync1, sync2, prev;
    logic [1:0]        settle;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        remaining;
    logic [1:0]        lat_cnt;
    logic [2:0]        fall;
    logic              cmd_single, cmd_scan, cmd_clear;
    logic              capture;

    // The three button flops reset to 1, but a button held low through
    // reset still ripples a 1->0 transition down the chain after release.
    // Edges are ignored until the chain has refilled with real samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            prev   <= '1;
            settle <= 2'd3;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            if (settle != 2'd0) begin
                settle <= settle - 2'd1;
            end
        end
    end

    assign fall       = (settle == 2'd0) ? (prev & ~sync2) : 3'b000;
    assign cmd_clear  = fall[2];
    assign cmd_scan   = fall[1];
    assign cmd_single = fall[0];

    assign capture = (state == WAIT) && (lat_cnt == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            lat_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (cmd_clear) begin
                // An in-flight read is simply abandoned; its data never lands.
                state     <= IDLE;
                data_out  <= '0;
                remaining <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cmd_scan || cmd_single) begin
                            state     <= ISSUE;
                            addr      <= ADDR_W'(BASE_ADDR);
                            remaining <= cmd_scan ? 8'(SCAN_LEN) : 8'd1;
                        end
                    end
                    ISSUE: begin
                        if (!wr_busy) begin
                            state   <= WAIT;
                            lat_cnt <= 2'(RD_LAT - 1);
                        end
                    end
                    WAIT: begin
                        if (capture) begin
                            data_out   <= rd_data;
                            data_valid <= 1'b1;
                            remaining  <= remaining - 8'd1;
                            addr       <= addr + 1'b1;
                            state      <= (remaining > 8'd1) ? ISSUE : IDLE;
                        end else begin
                            lat_cnt <= lat_cnt - 2'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // rd_en must follow wr_busy within the same cycle, so it is decoded
    // from the state register rather than registered itself.
    assign rd_en   = (state == ISSUE) && !wr_busy;
    assign rd_addr = addr;
    assign busy    = (state != IDLE);

`ifdef MEM_READER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
        end else if (cmd_clear) begin
            rd_count <= '0;
        end else if (capture && rd_count != 8'hFF) begin
            rd_count <= rd_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_reader.sv
// Testbench for mem_reader. Two instances share buttons and wr_busy:
// dut A uses the default parameters, dut B uses RD_LAT=2, BASE_ADDR=254 so
// its scans wrap the address space. Expected reads and captures come from a
// timing model built from the press-to-read and read-to-output rules.
module tb_mem_reader;

    localparam int LAT_A = 1, BASE_A = 6,   LEN_A = 4;
    localparam int LAT_B = 2, BASE_B = 254, LEN_B = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic       wr_busy;
    logic       rd_en_a, rd_en_b, dv_a, dv_b, busy_a, busy_b;
    logic [7:0] rd_addr_a, rd_addr_b, rd_data_a, rd_data_b, data_out_a, data_out_b;
`ifdef MEM_READER_CNT_EN
    logic [7:0] cnt_a, cnt_b;
`endif

    always #5 clk = ~clk;

    mem_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT_A), .BASE_ADDR(BASE_A), .SCAN_LEN(LEN_A)) dut_a (
        .clk(clk), .rst(rst), .btn(btn), .wr_busy(wr_busy),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .data_out(data_out_a), .data_valid(dv_a), .busy(busy_a)
`ifdef MEM_READER_CNT_EN
        , .rd_count(cnt_a)
`endif
    );

    mem_reader #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT_B), .BASE_ADDR(BASE_B), .SCAN_LEN(LEN_B)) dut_b (
        .clk(clk), .rst(rst), .btn(btn), .wr_busy(wr_busy),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .data_out(data_out_b), .data_valid(dv_b), .busy(busy_b)
`ifdef MEM_READER_CNT_EN
        , .rd_count(cnt_b)
`endif
    );

    // RAM model: data appears exactly RD_LAT cycles after rd_en, random junk otherwise
    logic [7:0] mem [256];
    logic [8:0] pa [3];
    logic [8:0] pb [3];
    logic [7:0] junk;

    always @(posedge clk) begin
        pa[0] <= {rd_en_a, mem[rd_addr_a]};
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pb[0] <= {rd_en_b, mem[rd_addr_b]};
        pb[1] <= pb[0];
        pb[2] <= pb[1];
        junk  <= 8'($urandom);
    end

    assign rd_data_a = pa[LAT_A-1][8] ? pa[LAT_A-1][7:0] : junk;
    assign rd_data_b = pb[LAT_B-1][8] ? pb[LAT_B-1][7:0] : junk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event logs
    int         rd_cyc [2][256];
    logic [7:0] rd_adr [2][256];
    int         dv_cyc [2][256];
    logic [7:0] dv_dat [2][256];
    int         rd_n [2] = '{0, 0};
    int         dv_n [2] = '{0, 0};

    always @(negedge clk) begin
        if (rd_en_a && rd_n[0] < 256) begin
            rd_cyc[0][rd_n[0]] <= cyc; rd_adr[0][rd_n[0]] <= rd_addr_a; rd_n[0] <= rd_n[0] + 1;
        end
        if (rd_en_b && rd_n[1] < 256) begin
            rd_cyc[1][rd_n[1]] <= cyc; rd_adr[1][rd_n[1]] <= rd_addr_b; rd_n[1] <= rd_n[1] + 1;
        end
        if (dv_a && dv_n[0] < 256) begin
            dv_cyc[0][dv_n[0]] <= cyc; dv_dat[0][dv_n[0]] <= data_out_a; dv_n[0] <= dv_n[0] + 1;
        end
        if (dv_b && dv_n[1] < 256) begin
            dv_cyc[1][dv_n[1]] <= cyc; dv_dat[1][dv_n[1]] <= data_out_b; dv_n[1] <= dv_n[1] + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int rb [2];
    int db [2];

    // expected events per dut
    int         e_rc [2][16];
    logic [7:0] e_ra [2][16];
    int         e_dc [2][16];
    logic [7:0] e_dd [2][16];
    int         e_rn [2];
    int         e_dn [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic press(input logic [2:0] m, input int w, output int n);
        n = cyc;
        btn = btn & ~m;
        repeat (w) tick();
        btn = btn | m;
    endtask

    task automatic snap();
        for (int d = 0; d < 2; d++) begin
            rb[d] = rd_n[d];
            db[d] = dv_n[d];
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    // Command first sampled low in cycle n0: read j issues at n0+3+stall+j*(lat+1),
    // its word appears lat+1 cycles later. A clear seen in cycle clr keeps
    // only events at or before clr.
    task automatic model(input int d, input int n0, input int nrd, input int stall, input int clr);
        int lat, base, ic, vc;
        logic [7:0] a;
        lat  = (d == 0) ? LAT_A : LAT_B;
        base = (d == 0) ? BASE_A : BASE_B;
        e_rn[d] = 0;
        e_dn[d] = 0;
        for (int j = 0; j < nrd; j++) begin
            ic = n0 + 3 + stall + j * (lat + 1);
            vc = ic + lat + 1;
            a  = 8'(base + j);
            if (clr < 0 || ic <= clr) begin
                e_rc[d][e_rn[d]] = ic; e_ra[d][e_rn[d]] = a; e_rn[d]++;
            end
            if (clr < 0 || vc <= clr) begin
                e_dc[d][e_dn[d]] = vc; e_dd[d][e_dn[d]] = mem[a]; e_dn[d]++;
            end
        end
    endtask

    task automatic test_reset();
        int r0 [2];
        rst = 1'b1; btn = 3'b111; wr_busy = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        checks++;
        if ({rd_en_a, rd_addr_a, data_out_a, dv_a, busy_a} !== 19'd0) begin
            errors++;
            $display("FAIL reset dut0: got rd_en=%b rd_addr=%0d data_out=%0d valid=%b busy=%b, expected all 0",
                     rd_en_a, rd_addr_a, data_out_a, dv_a, busy_a);
        end
        checks++;
        if ({rd_en_b, rd_addr_b, data_out_b, dv_b, busy_b} !== 19'd0) begin
            errors++;
            $display("FAIL reset dut1: got rd_en=%b rd_addr=%0d data_out=%0d valid=%b busy=%b, expected all 0",
                     rd_en_b, rd_addr_b, data_out_b, dv_b, busy_b);
        end
`ifdef MEM_READER_CNT_EN
        checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            errors++;
            $display("FAIL reset rd_count: got %0d/%0d, expected 0/0", cnt_a, cnt_b);
        end
`endif
        // button held low across reset release must not count as a press
        for (int d = 0; d < 2; d++) r0[d] = rd_n[d];
        btn = 3'b110; rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        btn = 3'b111;
        repeat (6) tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_n[d] - r0[d] !== 0) begin
                errors++;
                $display("FAIL held-through-reset dut%0d: got %0d reads, expected 0", d, rd_n[d] - r0[d]);
            end
        end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL held-through-reset busy: got %b/%b, expected 0/0", busy_a, busy_b);
        end
    endtask

    task automatic test_single();
        int n0;
        fill_mem();
        mem[6] = 8'd9;
        snap();
        press(3'b001, $urandom_range(1, 3), n0);
        wait_until(n0 + 5);
        checks++;
        if (data_out_a !== 8'd9 || dv_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL single N+5 dut0: got data_out=%0d valid=%b busy=%b, expected 9 1 0", data_out_a, dv_a, busy_a);
        end
        wait_until(n0 + 25);
        for (int d = 0; d < 2; d++) model(d, n0, 1, 0, -1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_n[d] - rb[d] !== e_rn[d] || dv_n[d] - db[d] !== e_dn[d]) begin
                errors++;
                $display("FAIL single counts dut%0d: got %0d reads %0d valids, expected %0d %0d", d, rd_n[d] - rb[d], dv_n[d] - db[d], e_rn[d], e_dn[d]);
            end
            for (int j = 0; j < e_rn[d]; j++) begin
                checks++;
                if (rd_cyc[d][rb[d]+j] !== e_rc[d][j] || rd_adr[d][rb[d]+j] !== e_ra[d][j]) begin
                    errors++;
                    $display("FAIL single read dut%0d #%0d: got cycle %0d addr %0d, expected cycle %0d addr %0d", d, j, rd_cyc[d][rb[d]+j], rd_adr[d][rb[d]+j], e_rc[d][j], e_ra[d][j]);
                end
            end
            for (int j = 0; j < e_dn[d]; j++) begin
                checks++;
                if (dv_cyc[d][db[d]+j] !== e_dc[d][j] || dv_dat[d][db[d]+j] !== e_dd[d][j]) begin
                    errors++;
                    $display("FAIL single data dut%0d #%0d: got cycle %0d data %0d, expected cycle %0d data %0d", d, j, dv_cyc[d][db[d]+j], dv_dat[d][db[d]+j], e_dc[d][j], e_dd[d][j]);
                end
            end
        end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || data_out_a !== 8'd9 || data_out_b !== mem[254]) begin
            errors++;
            $display("FAIL single hold: got busy %b/%b data_out %0d/%0d, expected 0/0 9/%0d", busy_a, busy_b, data_out_a, data_out_b, mem[254]);
        end
    endtask

    task automatic test_scan();
        int n0;
        fill_mem();
        snap();
        press(3'b010, $urandom_range(1, 3), n0);
        wait_until(n0 + 25);
        model(0, n0, LEN_A, 0, -1);
        model(1, n0, LEN_B, 0, -1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_n[d] - rb[d] !== e_rn[d] || dv_n[d] - db[d] !== e_dn[d]) begin
                errors++;
                $display("FAIL scan counts dut%0d: got %0d reads %0d valids, expected %0d %0d", d, rd_n[d] - rb[d], dv_n[d] - db[d], e_rn[d], e_dn[d]);
            end
            for (int j = 0; j < e_rn[d]; j++) begin
                checks++;
                if (rd_cyc[d][rb[d]+j] !== e_rc[d][j] || rd_adr[d][rb[d]+j] !== e_ra[d][j]) begin
                    errors++;
                    $display("FAIL scan read dut%0d #%0d: got cycle %0d addr %0d, expected cycle %0d addr %0d", d, j, rd_cyc[d][rb[d]+j], rd_adr[d][rb[d]+j], e_rc[d][j], e_ra[d][j]);
                end
            end
            for (int j = 0; j < e_dn[d]; j++) begin
                checks++;
                if (dv_cyc[d][db[d]+j] !== e_dc[d][j] || dv_dat[d][db[d]+j] !== e_dd[d][j]) begin
                    errors++;
                    $display("FAIL scan data dut%0d #%0d: got cycle %0d data %0d, expected cycle %0d data %0d", d, j, dv_cyc[d][db[d]+j], dv_dat[d][db[d]+j], e_dc[d][j], e_dd[d][j]);
                end
            end
        end
        checks++;
        if (data_out_a !== mem[9] || data_out_b !== mem[1] || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL scan end: got data_out %0d/%0d busy %b/%b, expected %0d/%0d 0/0", data_out_a, data_out_b, busy_a, busy_b, mem[9], mem[1]);
        end
    endtask

    task automatic test_stall();
        int n0, s;
        for (int it = 0; it < 3; it++) begin
            s = (it == 0) ? 5 : int'($urandom_range(1, 7));
            fill_mem();
            snap();
            press(3'b001, $urandom_range(1, 3), n0);
            wait_until(n0 + 3);
            wr_busy = 1'b1;
            #1;
            checks++;
            if (busy_a !== 1'b1 || busy_b !== 1'b1 || rd_en_a !== 1'b0 || rd_en_b !== 1'b0) begin
                errors++;
                $display("FAIL stall entry: got busy %b/%b rd_en %b/%b, expected 1/1 0/0", busy_a, busy_b, rd_en_a, rd_en_b);
            end
            repeat (s) tick();
            wr_busy = 1'b0;
            tick();
            // both instances are in WAIT now; wr_busy must be ignored there
            wr_busy = 1'b1;
            tick();
            wr_busy = 1'b0;
            wait_until(n0 + 30);
            for (int d = 0; d < 2; d++) model(d, n0, 1, s, -1);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rd_n[d] - rb[d] !== e_rn[d] || dv_n[d] - db[d] !== e_dn[d]) begin
                    errors++;
                    $display("FAIL stall%0d counts dut%0d: got %0d reads %0d valids, expected %0d %0d", s, d, rd_n[d] - rb[d], dv_n[d] - db[d], e_rn[d], e_dn[d]);
                end
                for (int j = 0; j < e_rn[d]; j++) begin
                    checks++;
                    if (rd_cyc[d][rb[d]+j] !== e_rc[d][j] || rd_adr[d][rb[d]+j] !== e_ra[d][j]) begin
                        errors++;
                        $display("FAIL stall%0d read dut%0d: got cycle %0d addr %0d, expected cycle %0d addr %0d", s, d, rd_cyc[d][rb[d]+j], rd_adr[d][rb[d]+j], e_rc[d][j], e_ra[d][j]);
                    end
                end
                for (int j = 0; j < e_dn[d]; j++) begin
                    checks++;
                    if (dv_cyc[d][db[d]+j] !== e_dc[d][j] || dv_dat[d][db[d]+j] !== e_dd[d][j]) begin
                        errors++;
                        $display("FAIL stall%0d data dut%0d: got cycle %0d data %0d, expected cycle %0d data %0d", s, d, dv_cyc[d][db[d]+j], dv_dat[d][db[d]+j], e_dc[d][j], e_dd[d][j]);
                    end
                end
            end
        end
    endtask

    task automatic test_clear();
        int n0, m, c;
        fill_mem();
        snap();
        press(3'b010, 1, n0);
        c = n0 + int'($urandom_range(4, 13));
        wait_until(c - 2);
        press(3'b100, 1, m);
        wait_until(c + 1);
        checks++;
        if (data_out_a !== 8'd0 || data_out_b !== 8'd0 || dv_a !== 1'b0 || dv_b !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL clear at %0d: got data_out %0d/%0d valid %b/%b busy %b/%b, expected all 0", c - n0, data_out_a, data_out_b, dv_a, dv_b, busy_a, busy_b);
        end
        wait_until(n0 + 25);
        checks++;
        if (data_out_a !== 8'd0 || data_out_b !== 8'd0) begin
            errors++;
            $display("FAIL clear hold: got data_out %0d/%0d, expected 0/0", data_out_a, data_out_b);
        end
        model(0, n0, LEN_A, 0, c);
        model(1, n0, LEN_B, 0, c);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_n[d] - rb[d] !== e_rn[d] || dv_n[d] - db[d] !== e_dn[d]) begin
                errors++;
                $display("FAIL clear counts dut%0d (clear at +%0d): got %0d reads %0d valids, expected %0d %0d", d, c - n0, rd_n[d] - rb[d], dv_n[d] - db[d], e_rn[d], e_dn[d]);
            end
            for (int j = 0; j < e_rn[d]; j++) begin
                checks++;
                if (rd_cyc[d][rb[d]+j] !== e_rc[d][j] || rd_adr[d][rb[d]+j] !== e_ra[d][j]) begin
                    errors++;
                    $display("FAIL clear read dut%0d #%0d: got cycle %0d addr %0d, expected cycle %0d addr %0d", d, j, rd_cyc[d][rb[d]+j], rd_adr[d][rb[d]+j], e_rc[d][j], e_ra[d][j]);
                end
            end
            for (int j = 0; j < e_dn[d]; j++) begin
                checks++;
                if (dv_cyc[d][db[d]+j] !== e_dc[d][j] || dv_dat[d][db[d]+j] !== e_dd[d][j]) begin
                    errors++;
                    $display("FAIL clear data dut%0d #%0d: got cycle %0d data %0d, expected cycle %0d data %0d", d, j, dv_cyc[d][db[d]+j], dv_dat[d][db[d]+j], e_dc[d][j], e_dd[d][j]);
                end
            end
        end
        // single read after the abort
        fill_mem();
        snap();
        press(3'b001, $urandom_range(1, 3), n0);
        wait_until(n0 + 25);
        for (int d = 0; d < 2; d++) model(d, n0, 1, 0, -1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_n[d] - rb[d] !== e_rn[d] || dv_n[d] - db[d] !== e_dn[d]) begin
                errors++;
                $display("FAIL post-clear counts dut%0d: got %0d reads %0d valids, expected %0d %0d", d, rd_n[d] - rb[d], dv_n[d] - db[d], e_rn[d], e_dn[d]);
            end
            for (int j = 0; j < e_dn[d]; j++) begin
                checks++;
                if (dv_cyc[d][db[d]+j] !== e_dc[d][j] || dv_dat[d][db[d]+j] !== e_dd[d][j]) begin
                    errors++;
                    $display("FAIL post-clear data dut%0d: got cycle %0d data %0d, expected cycle %0d data %0d", d, dv_cyc[d][db[d]+j], dv_dat[d][db[d]+j], e_dc[d][j], e_dd[d][j]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int n0, m;
        press(3'b100, 1, m);
        wait_until(m + 5);
        checks++;
        if (data_out_a !== 8'd0 || data_out_b !== 8'd0) begin
            errors++;
            $display("FAIL idle clear: got data_out %0d/%0d, expected 0/0", data_out_a, data_out_b);
        end
        fill_mem();
        snap();
        press(3'b011, $urandom_range(1, 3), n0);
        wait_until(n0 + 4);
        press(3'b001, 1, m);
        wait_until(n0 + 25);
        model(0, n0, LEN_A, 0, -1);
        model(1, n0, LEN_B, 0, -1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd_n[d] - rb[d] !== e_rn[d] || dv_n[d] - db[d] !== e_dn[d]) begin
                errors++;
                $display("FAIL simultaneous counts dut%0d: got %0d reads %0d valids, expected %0d %0d", d, rd_n[d] - rb[d], dv_n[d] - db[d], e_rn[d], e_dn[d]);
            end
            for (int j = 0; j < e_rn[d]; j++) begin
                checks++;
                if (rd_cyc[d][rb[d]+j] !== e_rc[d][j] || rd_adr[d][rb[d]+j] !== e_ra[d][j]) begin
                    errors++;
                    $display("FAIL simultaneous read dut%0d #%0d: got cycle %0d addr %0d, expected cycle %0d addr %0d", d, j, rd_cyc[d][rb[d]+j], rd_adr[d][rb[d]+j], e_rc[d][j], e_ra[d][j]);
                end
            end
            for (int j = 0; j < e_dn[d]; j++) begin
                checks++;
                if (dv_cyc[d][db[d]+j] !== e_dc[d][j] || dv_dat[d][db[d]+j] !== e_dd[d][j]) begin
                    errors++;
                    $display("FAIL simultaneous data dut%0d #%0d: got cycle %0d data %0d, expected cycle %0d data %0d", d, j, dv_cyc[d][db[d]+j], dv_dat[d][db[d]+j], e_dc[d][j], e_dd[d][j]);
                end
            end
        end
`ifdef MEM_READER_CNT_EN
        checks++;
        if (cnt_a !== 8'(LEN_A) || cnt_b !== 8'(LEN_B)) begin
            errors++;
            $display("FAIL rd_count after scan: got %0d/%0d, expected %0d/%0d", cnt_a, cnt_b, LEN_A, LEN_B);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int n0, s, nrd;
        logic [2:0] m;
        for (int it = 0; it < 5; it++) begin
            m   = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
            nrd = (m == 3'b010) ? LEN_A : 1;
            s   = int'($urandom_range(0, 2));
            fill_mem();
            snap();
            press(m, $urandom_range(1, 3), n0);
            wait_until(n0 + 3);
            if (s > 0) begin
                wr_busy = 1'b1;
                repeat (s) tick();
                wr_busy = 1'b0;
            end
            while ((busy_a || busy_b) && cyc < n0 + 40) tick();
            checks++;
            if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
                errors++;
                $display("FAIL back-to-back timeout it%0d: got busy %b/%b, expected 0/0", it, busy_a, busy_b);
            end
            tick();
            for (int d = 0; d < 2; d++) model(d, n0, nrd, s, -1);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rd_n[d] - rb[d] !== e_rn[d] || dv_n[d] - db[d] !== e_dn[d]) begin
                    errors++;
                    $display("FAIL back-to-back counts it%0d dut%0d: got %0d reads %0d valids, expected %0d %0d", it, d, rd_n[d] - rb[d], dv_n[d] - db[d], e_rn[d], e_dn[d]);
                end
                for (int j = 0; j < e_rn[d]; j++) begin
                    checks++;
                    if (rd_cyc[d][rb[d]+j] !== e_rc[d][j] || rd_adr[d][rb[d]+j] !== e_ra[d][j]) begin
                        errors++;
                        $display("FAIL back-to-back read it%0d dut%0d #%0d: got cycle %0d addr %0d, expected cycle %0d addr %0d", it, d, j, rd_cyc[d][rb[d]+j], rd_adr[d][rb[d]+j], e_rc[d][j], e_ra[d][j]);
                    end
                end
                for (int j = 0; j < e_dn[d]; j++) begin
                    checks++;
                    if (dv_cyc[d][db[d]+j] !== e_dc[d][j] || dv_dat[d][db[d]+j] !== e_dd[d][j]) begin
                        errors++;
                        $display("FAIL back-to-back data it%0d dut%0d #%0d: got cycle %0d data %0d, expected cycle %0d data %0d", it, d, j, dv_cyc[d][db[d]+j], dv_dat[d][db[d]+j], e_dc[d][j], e_dd[d][j]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_stall();
        test_clear();
        test_simultaneous();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
